pipe_register: RTL

- Parametrised multi-stage pipeline register: WIDTH-bit payload, STAGES-deep, valid/ready handshake on both sides.
- Adds bubble collapsing, synchronous flush and occupancy reporting.
- Used between multi-cycle datapath units, e.g. ALU result to memory stage, where a plain enable register cannot express back-pressure.

---
 rtl/pipe_register.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_register.sv
// pipe_register: STAGES-deep valid/ready pipeline register with bubble collapsing,
// synchronous flush and occupancy count. Define PIPE_REGISTER_SKID_EN for a registered-in_ready skid entry.
module pipe_register #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int CNT_W  = $clog2(STAGES + 2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] occupancy
);

   logic [STAGES-1:0]            r_v;
   logic [STAGES-1:0][WIDTH-1:0] r_d;
   logic [STAGES-1:0]            w_acc;
   logic                         w_in_xfer;
   logic                         w_s0_v;
   logic [WIDTH-1:0]             w_s0_d;

   function automatic logic [CNT_W-1:0] f_popcount(input logic [STAGES-1:0] v,
                                                   input logic            extra);
      logic [CNT_W-1:0] cnt;
      cnt = CNT_W'(extra);
      for (int i = 0; i < STAGES; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

   // A stage may load when it is empty or when everything downstream of it moves on.
   always_comb begin
      logic w_down;
      w_down = out_ready;
      w_acc  = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         w_down   = w_down | ~r_v[i];
         w_acc[i] = w_down;
      end
   end

`ifdef PIPE_REGISTER_SKID_EN
   logic             r_sv;
   logic [WIDTH-1:0] r_sd;

   assign in_ready  = ~flush & ~r_sv;
   assign w_in_xfer = in_valid & in_ready;
   // A parked skid entry is older than anything arriving, so it always wins stage 0.
   assign w_s0_v    = r_sv | w_in_xfer;
   assign w_s0_d    = r_sv ? r_sd : in_data;
   assign occupancy = f_popcount(r_v, r_sv);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sv <= 1'b0;
         r_sd <= '0;
      end else if (flush) begin
         r_sv <= 1'b0;
      end else if (r_sv) begin
         if (w_acc[0]) r_sv <= 1'b0;
      end else if (w_in_xfer && !w_acc[0]) begin
         r_sv <= 1'b1;
         r_sd <= in_data;
      end
   end
`else
   assign in_ready  = ~flush & w_acc[0];
   assign w_in_xfer = in_valid & in_ready;
   assign w_s0_v    = w_in_xfer;
   assign w_s0_d    = in_data;
   assign occupancy = f_popcount(r_v, 1'b0);
`endif

   // Stage registers: each stage takes its upstream neighbour whenever its advance term is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         r_d <= '0;
      end else if (flush) begin
         r_v <= '0;
      end else begin
         if (w_acc[0]) begin
            r_v[0] <= w_s0_v;
            r_d[0] <= w_s0_d;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (w_acc[i]) begin
               r_v[i] <= r_v[i-1];
               r_d[i] <= r_d[i-1];
            end
         end
      end
   end

   assign out_valid = r_v[STAGES-1] & ~flush;
   assign out_data  = r_d[STAGES-1];

endmodule
